// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: opcode/funct constants, reset PC and next-PC source encoding for pc_sequencer
package pc_seq_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  typedef enum logic [2:0] {SRC_PC4, SRC_BRANCH, SRC_JUMP, SRC_REG, SRC_REDIRECT} src_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_seq_if: decode/ALU-side inputs and fetch-side outputs of the PC sequencer
interface pc_seq_if;
  logic stall;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [15:0] branch_delta;
  logic [25:0] jump_index;
  logic [31:0] aluout;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] link_addr;
  logic ras_pred_valid;
  logic [31:0] ras_pred;
  logic ras_mispredict;
  logic ras_empty;
  logic ras_full;
  modport master (
    output stall, redirect_valid, redirect_pc, op, funct, rs, branch_delta, jump_index, aluout, rs_value,
    input pc, pc_next, link_addr, ras_pred_valid, ras_pred, ras_mispredict, ras_empty, ras_full
  );
  modport slave (
    input stall, redirect_valid, redirect_pc, op, funct, rs, branch_delta, jump_index, aluout, rs_value,
    output pc, pc_next, link_addr, ras_pred_valid, ras_pred, ras_mispredict, ras_empty, ras_full
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW:0] cnt;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign top = mem[ptr - AW'(1)];
  // ptr is the next free slot; when full it aliases the oldest entry, so a push overwrites it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr <= ptr + AW'(1);
      cnt <= full ? cnt : cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered MIPS next-PC sequencer; define PC_SEQ_RAS_EN to build the return-address stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  pc_seq_if.slave bus
);
  logic [31:0] pc_q, pc4, br_tgt, jmp_tgt, target, pc_next_c;
  logic is_jr, is_jalr, br_taken;
  src_e src;
  assign pc4 = pc_q + 32'd4;
  assign br_tgt = pc4 + {{14{bus.branch_delta[15]}}, bus.branch_delta, 2'b00};
  assign jmp_tgt = {pc_q[31:28], bus.jump_index, 2'b00};
  assign is_jr = bus.op == OP_SPECIAL && bus.funct == FN_JR;
  assign is_jalr = bus.op == OP_SPECIAL && bus.funct == FN_JALR;
  assign br_taken = (bus.op == OP_BEQ && bus.aluout == '0) || (bus.op == OP_BNE && bus.aluout != '0);
  // pick the next-PC source (redirect outranks the instruction) and its target
  always_comb begin
    src = bus.redirect_valid ? SRC_REDIRECT :
          br_taken ? SRC_BRANCH :
          (bus.op == OP_J || bus.op == OP_JAL) ? SRC_JUMP :
          (is_jr || is_jalr) ? SRC_REG : SRC_PC4;
    target = src == SRC_REDIRECT ? bus.redirect_pc :
             src == SRC_BRANCH ? br_tgt :
             src == SRC_JUMP ? jmp_tgt :
             src == SRC_REG ? bus.rs_value : pc4;
    pc_next_c = !rst_n ? RESET_PC : (bus.stall && !bus.redirect_valid) ? pc_q : target;
  end
  // program counter register
  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_next_c;
  end
  assign bus.pc = pc_q;
  assign bus.pc_next = pc_next_c;
  assign bus.link_addr = pc4;
`ifdef PC_SEQ_RAS_EN
  logic advance, is_call, jr31, ras_empty, pred_valid;
  logic [31:0] ras_top;
  assign advance = rst_n & ~bus.stall & ~bus.redirect_valid;
  assign is_call = bus.op == OP_JAL || is_jalr;
  assign jr31 = is_jr && bus.rs == 5'd31;
  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(advance & is_call),
    .pop(advance & jr31),
    .push_data(pc4),
    .top(ras_top),
    .empty(ras_empty),
    .full(bus.ras_full)
  );
  assign pred_valid = rst_n & jr31 & ~ras_empty;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_pred = ras_top;
  assign bus.ras_pred_valid = pred_valid;
  assign bus.ras_mispredict = pred_valid && ras_top != bus.rs_value;
`else
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full = 1'b0;
  assign bus.ras_pred = '0;
  assign bus.ras_pred_valid = 1'b0;
  assign bus.ras_mispredict = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table, directed and random checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  typedef struct packed {
    logic stall;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [15:0] branch_delta;
    logic [25:0] jump_index;
    logic [31:0] aluout;
    logic [31:0] rs_value;
  } in_t;
  typedef struct {
    string name;
    in_t in;
    logic [31:0] exp_next;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pc_seq_if bus();
  pc_sequencer #(.RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  in_t cur;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ras[$];
  logic [31:0] e_next;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rs,
                             input logic [15:0] delta, input logic [25:0] idx,
                             input logic [31:0] alu, input logic [31:0] rsv);
    in_t v;
    v = '0;
    v.op = op;
    v.funct = funct;
    v.rs = rs;
    v.branch_delta = delta;
    v.jump_index = idx;
    v.aluout = alu;
    v.rs_value = rsv;
    return v;
  endfunction

  function automatic in_t redir(input logic [31:0] target);
    in_t v;
    v = '0;
    v.redirect_valid = 1'b1;
    v.redirect_pc = target;
    v.funct = 6'h20;
    return v;
  endfunction

  // expected next fetch address straight from the instruction semantics
  function automatic logic [31:0] model_next();
    logic [31:0] p4, t;
    int off;
    p4 = m_pc + 32'd4;
    off = 4 * int'($signed(cur.branch_delta));
    t = p4;
    case (cur.op)
      6'd4: if (cur.aluout == 0) t = p4 + 32'(off);
      6'd5: if (cur.aluout != 0) t = p4 + 32'(off);
      6'd2, 6'd3: t = (m_pc & 32'hF000_0000) | (32'(cur.jump_index) * 4);
      6'd0: if (cur.funct == 6'd8 || cur.funct == 6'd9) t = cur.rs_value;
      default: t = p4;
    endcase
    if (!rst_n) return RST_PC;
    if (cur.redirect_valid) return cur.redirect_pc;
    if (cur.stall) return m_pc;
    return t;
  endfunction

  function automatic bit is_jr31();
    return cur.op == 6'd0 && cur.funct == 6'd8 && cur.rs == 5'd31;
  endfunction

  task automatic drive();
    bus.stall = cur.stall;
    bus.redirect_valid = cur.redirect_valid;
    bus.redirect_pc = cur.redirect_pc;
    bus.op = cur.op;
    bus.funct = cur.funct;
    bus.rs = cur.rs;
    bus.branch_delta = cur.branch_delta;
    bus.jump_index = cur.jump_index;
    bus.aluout = cur.aluout;
    bus.rs_value = cur.rs_value;
  endtask

  task automatic apply_and_check();
    bit pv;
    drive();
    #3;
    e_next = model_next();
    pv = RAS_EN && rst_n && is_jr31() && m_ras.size() > 0;
    chk("pc_next", bus.pc_next, e_next);
    if (rst_n) chk("link_addr", bus.link_addr, m_pc + 32'd4);
    chk("ras_pred_valid", 32'(bus.ras_pred_valid), 32'(pv));
    chk("ras_mispredict", 32'(bus.ras_mispredict), 32'(pv && m_ras[$] != cur.rs_value));
    if (pv) chk("ras_pred", bus.ras_pred, m_ras[$]);
    if (!RAS_EN) chk("ras_pred_tied", bus.ras_pred, 32'h0);
  endtask

  task automatic finish_cycle();
    bit adv;
    @(posedge clk);
    adv = rst_n && !cur.stall && !cur.redirect_valid;
    if (!rst_n) m_ras.delete();
    else if (adv && (cur.op == 6'd3 || (cur.op == 6'd0 && cur.funct == 6'd9))) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (adv && is_jr31() && m_ras.size() > 0) void'(m_ras.pop_back());
    m_pc = e_next;
    #1;
    chk("pc", bus.pc, m_pc);
    chk("ras_empty", 32'(bus.ras_empty), 32'(!RAS_EN || m_ras.size() == 0));
    chk("ras_full", 32'(bus.ras_full), 32'(RAS_EN && m_ras.size() == DEPTH));
  endtask

  task automatic cycle(input in_t v);
    cur = v;
    apply_and_check();
    finish_cycle();
  endtask

  initial begin
    logic [31:0] links[$];
    logic [31:0] pc_hold;
    int pushes;
    tbl[0] = '{"beq_back", mk(6'd4, 6'd0, 5'd1, 16'hFFFE, 26'd0, 32'd0, 32'd0), 32'h0000_300C};
    tbl[1] = '{"beq_not", mk(6'd4, 6'd0, 5'd1, 16'hFFFE, 26'd0, 32'd5, 32'd0), 32'h0000_3014};
    tbl[2] = '{"bne_taken", mk(6'd5, 6'd0, 5'd1, 16'hFFFE, 26'd0, 32'd5, 32'd0), 32'h0000_300C};
    tbl[3] = '{"bne_not", mk(6'd5, 6'd0, 5'd1, 16'hFFFE, 26'd0, 32'd0, 32'd0), 32'h0000_3014};
    tbl[4] = '{"beq_fwd", mk(6'd4, 6'd0, 5'd1, 16'h0010, 26'd0, 32'd0, 32'd0), 32'h0000_3054};
    tbl[5] = '{"j", mk(6'd2, 6'd0, 5'd0, 16'h0, 26'h0001000, 32'd1, 32'd0), 32'h0000_4000};
    tbl[6] = '{"jr_r4", mk(6'd0, 6'd8, 5'd4, 16'h0, 26'd0, 32'd1, 32'h1234_5678), 32'h1234_5678};
    tbl[7] = '{"jalr", mk(6'd0, 6'd9, 5'd2, 16'h0, 26'd0, 32'd1, 32'h0040_0000), 32'h0040_0000};
    tbl[8] = '{"lw_seq", mk(6'h23, 6'd8, 5'd31, 16'h0, 26'd0, 32'd0, 32'd0), 32'h0000_3014};
    tbl[9] = '{"add_seq", mk(6'd0, 6'h20, 5'd31, 16'h0, 26'd0, 32'd0, 32'd0), 32'h0000_3014};
    tbl[10] = '{"stall_beq", mk(6'd4, 6'd0, 5'd1, 16'hFFFE, 26'd0, 32'd0, 32'd0), 32'h0000_3010};
    tbl[10].in.stall = 1'b1;
    tbl[11] = '{"redir_stall", mk(6'd3, 6'd0, 5'd0, 16'h0, 26'h1, 32'd0, 32'd0), 32'h8000_0180};
    tbl[11].in.stall = 1'b1;
    tbl[11].in.redirect_valid = 1'b1;
    tbl[11].in.redirect_pc = 32'h8000_0180;
    tbl[12] = '{"beq_wrap", mk(6'd4, 6'd0, 5'd1, 16'h8000, 26'd0, 32'd0, 32'd0), 32'hFFFE_3014};

    // reset held two cycles, then a plain sequential instruction
    cur = '0;
    rst_n = 1'b0;
    cycle(mk(6'd2, 6'd0, 5'd0, 16'h0, 26'h3FF, 32'd0, 32'd0));
    cycle('0);
    chk("reset_pc", bus.pc, 32'h0000_3000);
    chk("reset_empty", 32'(bus.ras_empty), 32'd1);
    rst_n = 1'b1;
    cycle('0);
    chk("pc_after_reset", bus.pc, 32'h0000_3004);

    // decode table, each entry issued from pc = 0x3010
    foreach (tbl[i]) begin
      cycle(redir(32'h0000_3010));
      cur = tbl[i].in;
      apply_and_check();
      chk({"tbl_", tbl[i].name}, bus.pc_next, tbl[i].exp_next);
      finish_cycle();
    end

    // call/return: JAL then JR $31 (first stalled and correct, then mispredicted)
    rst_n = 1'b0;
    cycle('0);
    rst_n = 1'b1;
    cycle(redir(32'h0000_3020));
    cur = mk(6'd3, 6'd0, 5'd0, 16'h0, 26'h0001000, 32'd0, 32'd0);
    apply_and_check();
    chk("jal_link", bus.link_addr, 32'h0000_3024);
    finish_cycle();
    chk("jal_pc", bus.pc, 32'h0000_4000);
    cur = mk(6'd0, 6'd8, 5'd31, 16'h0, 26'd0, 32'd0, 32'h0000_3024);
    cur.stall = 1'b1;
    apply_and_check();
    chk("jr_pred_valid", 32'(bus.ras_pred_valid), 32'(RAS_EN));
    chk("jr_pred_ok", 32'(bus.ras_mispredict), 32'd0);
    finish_cycle();
    cur = mk(6'd0, 6'd8, 5'd31, 16'h0, 26'd0, 32'd0, 32'h0000_5000);
    apply_and_check();
    chk("jr_mispredict", 32'(bus.ras_mispredict), 32'(RAS_EN));
    finish_cycle();
    chk("jr_pc", bus.pc, 32'h0000_5000);

    // overflow: five calls, four returns newest first, fifth return finds nothing
    links.delete();
    for (int k = 0; k < 5; k++) begin
      cycle(redir(32'h0001_0000 + 32'(k) * 32'h100));
      links.push_back(32'h0001_0004 + 32'(k) * 32'h100);
      cycle(mk(6'd3, 6'd0, 5'd0, 16'h0, 26'h0002000, 32'd0, 32'd0));
    end
    chk("ovf_full", 32'(bus.ras_full), 32'(RAS_EN));
    for (int k = 0; k < 5; k++) begin
      cur = mk(6'd0, 6'd8, 5'd31, 16'h0, 26'd0, 32'd0, links[4 - k]);
      apply_and_check();
      chk("ovf_pop_valid", 32'(bus.ras_pred_valid), 32'(RAS_EN && k < 4));
      if (RAS_EN && k < 4) chk("ovf_pop_value", bus.ras_pred, links[4 - k]);
      finish_cycle();
    end

    // stalled JAL pushes exactly once on release; redirect blocks a push
    pc_hold = bus.pc;
    for (int k = 0; k < 3; k++) begin
      cur = mk(6'd3, 6'd0, 5'd0, 16'h0, 26'h0003000, 32'd0, 32'd0);
      cur.stall = 1'b1;
      apply_and_check();
      finish_cycle();
      chk("stall_pc", bus.pc, pc_hold);
      chk("stall_no_push", 32'(bus.ras_empty), 32'd1);
    end
    cycle(mk(6'd3, 6'd0, 5'd0, 16'h0, 26'h0003000, 32'd0, 32'd0));
    pushes = 0;
    for (int k = 0; k < 2; k++) begin
      cur = mk(6'd0, 6'd8, 5'd31, 16'h0, 26'd0, 32'd0, pc_hold + 32'd4);
      apply_and_check();
      pushes += int'(bus.ras_pred_valid);
      finish_cycle();
    end
    chk("release_one_push", 32'(pushes), 32'(RAS_EN));
    cur = mk(6'd3, 6'd0, 5'd0, 16'h0, 26'h0003000, 32'd0, 32'd0);
    cur.stall = 1'b1;
    cur.redirect_valid = 1'b1;
    cur.redirect_pc = 32'h8000_0180;
    apply_and_check();
    finish_cycle();
    chk("redirect_pc", bus.pc, 32'h8000_0180);
    chk("redirect_no_push", 32'(bus.ras_empty), 32'd1);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_t v;
      int sel;
      logic [5:0] ops[6];
      ops = '{6'd0, 6'd4, 6'd5, 6'd2, 6'd3, 6'h23};
      sel = $urandom_range(0, 5);
      v = '0;
      v.op = ops[sel];
      v.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (($urandom_range(0, 1) == 1) ? 6'd8 : 6'd9);
      v.rs = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom);
      v.branch_delta = 16'($urandom);
      v.jump_index = 26'($urandom);
      v.aluout = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
      v.rs_value = ($urandom_range(0, 1) == 1 && m_ras.size() > 0) ? m_ras[$] : $urandom;
      v.stall = $urandom_range(0, 4) == 0;
      v.redirect_valid = $urandom_range(0, 9) == 0;
      v.redirect_pc = $urandom;
      rst_n = $urandom_range(0, 39) != 0;
      cycle(v);
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
